// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, defaults and constants for mem_access_ctrl
package mem_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IP_ACC  = 2'd2,
        DONE    = 2'd3
    } state_t;
    localparam int   MEM_WAIT_DEF = 2;
    localparam int   IP_TMO_DEF   = 64;
    localparam logic RW_READ      = 1'b1;
endpackage

// File: rtl/mem_access_ctrl_wait_cnt.sv
// mem_wait_cnt: loadable up/down counter with zero flag (SRAM wait and IP timeout)
module mem_wait_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] cnt,
    output logic         zero
);
    // load takes priority over counting; direction chosen per access type
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage controller for data SRAM and IP port; MEM_IP_TIMEOUT_EN adds IP timeout and ip_err
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int MEM_WAIT = MEM_WAIT_DEF,
    parameter int IP_TMO   = IP_TMO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ena,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_ip_write,
    input  logic              req_ip_read,
    output logic              count,
    output logic              busy,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ip_wr,
    output logic              ip_rd,
    output logic [ADDR_W-1:0] ip_addr,
    output logic [DATA_W-1:0] ip_wdata,
    input  logic [DATA_W-1:0] ip_rdata,
    input  logic              ip_ready,
    output logic [DATA_W-1:0] rdata_out,
`ifdef MEM_IP_TIMEOUT_EN
    output logic              ip_err,
`endif
    output logic              rdata_valid
);
    localparam int CW = $clog2((IP_TMO > 16 ? IP_TMO : 16) + 1);

    state_t          state;
    logic            rd_q;
    logic [CW-1:0]   cnt;
    logic            cnt_zero;
    logic            cnt_load;
    logic            cnt_en;
    logic            ip_route;
    logic            req_rd;
    logic            tmo;

    assign ip_route    = req_ip_write | req_ip_read;
    assign req_rd      = req_ip_write ? 1'b0 : req_ip_read ? 1'b1 : req_rw == RW_READ;
    assign count       = state == DONE;
    assign busy        = state != IDLE;
    assign rdata_valid = state == DONE && rd_q;

    // counter loads on accept: wait length for SRAM, zero for IP timeout
    always_comb begin
        cnt_load = state == IDLE && req_ena;
        cnt_en   = state == MEM_ACC && !cnt_zero;
`ifdef MEM_IP_TIMEOUT_EN
        cnt_en   = cnt_en || state == IP_ACC;
        tmo      = state == IP_ACC && cnt == CW'(IP_TMO - 1);
`else
        tmo      = 1'b0;
`endif
    end

    mem_wait_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (ip_route ? '0 : CW'(MEM_WAIT - 1)),
        .en       (cnt_en),
        .up       (state == IP_ACC),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // access FSM with registered strobes, address/data capture and load data latch
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            rd_q      <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ip_wr     <= 1'b0;
            ip_rd     <= 1'b0;
            ip_addr   <= '0;
            ip_wdata  <= '0;
            rdata_out <= '0;
`ifdef MEM_IP_TIMEOUT_EN
            ip_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:
                    if (req_ena) begin
                        rd_q <= req_rd;
                        if (ip_route) begin
                            state    <= IP_ACC;
                            ip_addr  <= req_addr;
                            ip_wdata <= req_wdata;
                            ip_wr    <= req_ip_write;
                            ip_rd    <= ~req_ip_write;
                        end else begin
                            state     <= MEM_ACC;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_wdata;
                            mem_cs    <= 1'b1;
                            mem_we    <= req_rw != RW_READ;
                        end
                    end
                MEM_ACC:
                    if (cnt_zero) begin
                        if (rd_q)
                            rdata_out <= mem_rdata;
                        mem_cs <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end
                IP_ACC:
                    if (ip_ready || tmo) begin
                        if (rd_q)
                            rdata_out <= ip_ready ? ip_rdata : '0;
`ifdef MEM_IP_TIMEOUT_EN
                        if (!ip_ready)
                            ip_err <= 1'b1;
`endif
                        ip_wr <= 1'b0;
                        ip_rd <= 1'b0;
                        state <= DONE;
                    end
                default:
                    state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: randomized self-checking bench against a cycle-count reference model
module tb_mem_access_ctrl;
    localparam int MW  = 2;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_ena = 1'b0, req_rw = 1'b0, req_ip_write = 1'b0, req_ip_read = 1'b0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_wdata = '0, mem_rdata = '0, ip_rdata = '0;
    logic        ip_ready = 1'b0;
    logic        count, busy, mem_cs, mem_we, ip_wr, ip_rd, rdata_valid, ip_err;
    logic [19:0] mem_addr, ip_addr;
    logic [31:0] mem_wdata, ip_wdata, rdata_out;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_rdata = '0;

    mem_access_ctrl #(.ADDR_W(20), .DATA_W(32), .MEM_WAIT(MW), .IP_TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req_ena(req_ena), .req_rw(req_rw), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ip_write(req_ip_write), .req_ip_read(req_ip_read),
        .count(count), .busy(busy), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .ip_wr(ip_wr), .ip_rd(ip_rd),
        .ip_addr(ip_addr), .ip_wdata(ip_wdata), .ip_rdata(ip_rdata), .ip_ready(ip_ready),
        .rdata_out(rdata_out),
`ifdef MEM_IP_TIMEOUT_EN
        .ip_err(ip_err),
`endif
        .rdata_valid(rdata_valid)
    );

`ifndef MEM_IP_TIMEOUT_EN
    assign ip_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // Drives one request starting at the current (negedge) time and measures it.
    // Cycle c is the c-th cycle after the accepting edge.
    task automatic run_access(input bit rw, input bit ipw, input bit ipr, input bit hold, input bit drop,
                              input logic [19:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int stall, output int lat, output int strb, output int side_bad,
                              output bit rv);
        req_ena = 1'b1; req_rw = rw; req_ip_write = ipw; req_ip_read = ipr;
        req_addr = a; req_wdata = wd; mem_rdata = rd; ip_rdata = rd; ip_ready = 1'b0;
        lat = -1; strb = 0; side_bad = 0; rv = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (drop) req_ena = 1'b0;
            if (mem_cs) begin
                strb++;
                if (mem_we !== !rw || mem_addr !== a || mem_wdata !== wd) side_bad++;
            end
            if (ip_wr || ip_rd) begin
                strb++;
                if (ip_wr !== ipw || ip_rd !== !ipw || ip_addr !== a || ip_wdata !== wd) side_bad++;
            end
            if (count) begin
                lat = c;
                rv = rdata_valid;
                if (!hold) req_ena = 1'b0;
                ip_ready = 1'b0;
                break;
            end
            ip_ready = (ipw || ipr) && c > stall;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({count, busy, mem_cs, mem_we, ip_wr, ip_rd, rdata_valid, ip_err} !== 8'h00) begin
            bad++; $display("FAIL reset_strobes got %b want 00000000",
                {count, busy, mem_cs, mem_we, ip_wr, ip_rd, rdata_valid, ip_err});
        end
        total++;
        if ({mem_addr, mem_wdata, ip_addr, ip_wdata, rdata_out} !== '0) begin
            bad++; $display("FAIL reset_regs got %h/%h/%h/%h/%h want all 0",
                mem_addr, mem_wdata, ip_addr, ip_wdata, rdata_out);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b want 0", busy); end
    endtask

    task automatic test_mem_read;
        int lat, strb, sb; bit rv;
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 32'h0, 32'hDEADBEEF, 0, lat, strb, sb, rv);
        exp_rdata = 32'hDEADBEEF;
        total++; if (lat !== MW + 1) begin bad++; $display("FAIL mrd_latency got %0d want %0d", lat, MW + 1); end
        total++; if (strb !== MW) begin bad++; $display("FAIL mrd_cs_cycles got %0d want %0d", strb, MW); end
        total++; if (sb !== 0) begin bad++; $display("FAIL mrd_side got %0d want 0", sb); end
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL mrd_valid got %b want 1", rv); end
        total++; if (rdata_out !== exp_rdata) begin bad++; $display("FAIL mrd_data got %h want %h", rdata_out, exp_rdata); end
    endtask

    task automatic test_mem_write;
        int lat, strb, sb; bit rv;
        @(negedge clk);
        run_access(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00020, 32'h12345678, 32'h0BADF00D, 0, lat, strb, sb, rv);
        total++; if (lat !== MW + 1) begin bad++; $display("FAIL mwr_latency got %0d want %0d", lat, MW + 1); end
        total++; if (strb !== MW) begin bad++; $display("FAIL mwr_we_cycles got %0d want %0d", strb, MW); end
        total++; if (sb !== 0) begin bad++; $display("FAIL mwr_side got %0d want 0", sb); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL mwr_valid got %b want 0", rv); end
        total++; if (rdata_out !== exp_rdata) begin bad++; $display("FAIL mwr_keep got %h want %h", rdata_out, exp_rdata); end
    endtask

    task automatic test_ip_read_stall;
        int lat, strb, sb; bit rv;
        @(negedge clk);
        run_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'hF0004, 32'h0, 32'hA5A5A5A5, 4, lat, strb, sb, rv);
        exp_rdata = 32'hA5A5A5A5;
        total++; if (lat !== 6) begin bad++; $display("FAIL iprd_latency got %0d want 6", lat); end
        total++; if (strb !== 5) begin bad++; $display("FAIL iprd_rd_cycles got %0d want 5", strb); end
        total++; if (sb !== 0) begin bad++; $display("FAIL iprd_side got %0d want 0", sb); end
        total++; if (rdata_out !== exp_rdata) begin bad++; $display("FAIL iprd_data got %h want %h", rdata_out, exp_rdata); end
    endtask

    task automatic test_ip_both_flags;
        int lat, strb, sb; bit rv;
        @(negedge clk);
        run_access(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 20'h0ABCD, 32'hCAFE0001, 32'h77777777, 0, lat, strb, sb, rv);
        total++; if (lat !== 2) begin bad++; $display("FAIL ipboth_latency got %0d want 2", lat); end
        total++; if (sb !== 0 || strb !== 1) begin bad++; $display("FAIL ipboth_write side=%0d cycles=%0d want 0/1", sb, strb); end
        total++; if (rv !== 1'b0 || rdata_out !== exp_rdata) begin
            bad++; $display("FAIL ipboth_nodata valid=%b data=%h want 0/%h", rv, rdata_out, exp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int lat, strb, sb, extra; bit rv;
        @(negedge clk);
        run_access(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20'h00100, 32'h0, 32'h11111111, 0, lat, strb, sb, rv);
        total++; if (lat !== MW + 1) begin bad++; $display("FAIL b2b_first got %0d want %0d", lat, MW + 1); end
        @(negedge clk);
        total++; if (busy !== 1'b0 || count !== 1'b0) begin
            bad++; $display("FAIL b2b_no_dup busy=%b count=%b want 0/0", busy, count);
        end
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00104, 32'h0, 32'h22222222, 0, lat, strb, sb, rv);
        exp_rdata = 32'h22222222;
        total++; if (lat !== MW + 1 || sb !== 0) begin bad++; $display("FAIL b2b_second lat=%0d side=%0d want %0d/0", lat, sb, MW + 1); end
        total++; if (rdata_out !== exp_rdata) begin bad++; $display("FAIL b2b_data got %h want %h", rdata_out, exp_rdata); end
        extra = 0;
        repeat (8) begin @(negedge clk); if (count || busy) extra++; end
        total++; if (extra !== 0) begin bad++; $display("FAIL b2b_extra got %0d want 0", extra); end
    endtask

    task automatic test_drop_enable;
        int lat, strb, sb; bit rv;
        @(negedge clk);
        run_access(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 20'h00200, 32'h5555AAAA, 32'h0, 0, lat, strb, sb, rv);
        total++; if (lat !== MW + 1 || strb !== MW) begin
            bad++; $display("FAIL drop_completes lat=%0d cycles=%0d want %0d/%0d", lat, strb, MW + 1, MW);
        end
    endtask

    task automatic test_reset_mid;
        int lat, strb, sb, seen; bit rv;
        @(negedge clk);
        req_ena = 1'b1; req_rw = 1'b1; req_ip_write = 1'b0; req_ip_read = 1'b0;
        req_addr = 20'h00300; mem_rdata = 32'h99999999;
        @(negedge clk);
        @(posedge clk);
        #1;
        total++; if (mem_cs !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_active cs=%b busy=%b want 1/1", mem_cs, busy); end
        rst = 1'b1;
        #1;
        total++; if (mem_cs !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_async cs=%b busy=%b want 0/0", mem_cs, busy); end
        req_ena = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (count) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_nocount got %0d want 0", seen); end
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00304, 32'h0, 32'h31415926, 0, lat, strb, sb, rv);
        exp_rdata = 32'h31415926;
        total++; if (lat !== MW + 1 || rdata_out !== exp_rdata) begin
            bad++; $display("FAIL rstmid_next lat=%0d data=%h want %0d/%h", lat, rdata_out, MW + 1, exp_rdata);
        end
    endtask

    task automatic test_random;
        int lat, strb, sb, elat, estrb, route, stall; bit rv, rw, ipw, ipr, is_rd;
        logic [19:0] a; logic [31:0] wd, rd;
        for (int n = 0; n < 24; n++) begin
            route = $urandom_range(0, 3);
            rw = 1'($urandom_range(0, 1));
            ipw = route == 1 || route == 3;
            ipr = route == 2 || route == 3;
            stall = $urandom_range(0, 5);
            a = 20'($urandom); wd = $urandom; rd = $urandom;
            is_rd = ipw ? 1'b0 : ipr ? 1'b1 : rw;
            elat = (ipw || ipr) ? stall + 2 : MW + 1;
            estrb = (ipw || ipr) ? stall + 1 : MW;
            if (is_rd) exp_rdata = rd;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            run_access(rw, ipw, ipr, 1'b0, 1'b0, a, wd, rd, stall, lat, strb, sb, rv);
            total++;
            if (lat !== elat || strb !== estrb || sb !== 0 || rv !== is_rd || rdata_out !== exp_rdata) begin
                bad++;
                $display("FAIL rand%0d lat=%0d/%0d strb=%0d/%0d side=%0d rv=%b/%b data=%h/%h",
                    n, lat, elat, strb, estrb, sb, rv, is_rd, rdata_out, exp_rdata);
            end
        end
    endtask

`ifdef MEM_IP_TIMEOUT_EN
    task automatic test_timeout;
        int lat, strb, sb; bit rv;
        @(negedge clk);
        total++; if (ip_err !== 1'b0) begin bad++; $display("FAIL tmo_err_clear got %b want 0", ip_err); end
        run_access(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0F00F, 32'hFEEDFACE, 32'h0, 100000, lat, strb, sb, rv);
        total++; if (strb !== TMO || lat !== TMO + 1) begin
            bad++; $display("FAIL tmo_write cycles=%0d lat=%0d want %0d/%0d", strb, lat, TMO, TMO + 1);
        end
        total++; if (ip_err !== 1'b1) begin bad++; $display("FAIL tmo_err_set got %b want 1", ip_err); end
        @(negedge clk);
        run_access(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0F010, 32'h0, 32'h13579BDF, 100000, lat, strb, sb, rv);
        exp_rdata = '0;
        total++; if (rdata_out !== exp_rdata || rv !== 1'b1) begin
            bad++; $display("FAIL tmo_read data=%h valid=%b want %h/1", rdata_out, rv, exp_rdata);
        end
        @(negedge clk);
        run_access(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0F020, 32'h0, 32'h2468ACE0, 0, lat, strb, sb, rv);
        total++; if (ip_err !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky got %b want 1", ip_err); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        total++; if (ip_err !== 1'b0) begin bad++; $display("FAIL tmo_err_rst got %b want 0", ip_err); end
    endtask
`endif

    initial begin
        test_reset;
        test_mem_read;
        test_mem_write;
        test_ip_read_stall;
        test_ip_both_flags;
        test_back_to_back;
        test_drop_enable;
        test_reset_mid;
        test_random;
`ifdef MEM_IP_TIMEOUT_EN
        test_timeout;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
